// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage: operation codes, FSM states,
// flag bit positions and small op-classification helpers.
package alu_exec_pkg;

   localparam logic [3:0] OP_AND    = 4'b0000;
   localparam logic [3:0] OP_ORR    = 4'b0001;
   localparam logic [3:0] OP_ADD    = 4'b0010;
   localparam logic [3:0] OP_SUB    = 4'b0110;
   localparam logic [3:0] OP_XNOR   = 4'b0101;
   localparam logic [3:0] OP_LSL    = 4'b0111;
   localparam logic [3:0] OP_LSR    = 4'b1000;
   localparam logic [3:0] OP_SHCMP  = 4'b1001;
   localparam logic [3:0] OP_SUBSTR = 4'b1010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SHIFT,
      ST_SCAN,
      ST_DONE
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_LSL) || (op == OP_LSR) || (op == OP_SHCMP);
   endfunction

   // Unlisted codes fall back to ADD, so they carry C/V like ADD does.
   function automatic logic has_carry_flags(input logic [3:0] op);
      return !(op inside {OP_AND, OP_ORR, OP_XNOR, OP_LSL, OP_LSR, OP_SHCMP, OP_SUBSTR});
   endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// Shift engine for LSL/LSR/shift-compare. Defining BARREL_SHIFT_EN selects a
// single-cycle barrel shifter; otherwise the data is shifted one bit per cycle.
module alu_exec_shifter
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int SHAMT_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  right,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [SHAMT_W-1:0]    amount,
   output logic [DATA_WIDTH-1:0] value,
   output logic                  last,
   output logic                  multi_cycle
);

   logic [DATA_WIDTH-1:0] data_q;
   logic [SHAMT_W-1:0]    count_q;
   logic                  right_q;

`ifdef BARREL_SHIFT_EN

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q  <= '0;
         count_q <= '0;
         right_q <= 1'b0;
      end else if (load) begin
         data_q  <= data;
         count_q <= amount;
         right_q <= right;
      end
   end

   assign value       = right_q ? (data_q >> count_q) : (data_q << count_q);
   assign last        = 1'b1;
   assign multi_cycle = 1'b0;

`else

   logic [DATA_WIDTH-1:0] step;

   assign step = right_q ? (data_q >> 1) : (data_q << 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q  <= '0;
         count_q <= '0;
         right_q <= 1'b0;
      end else if (load) begin
         data_q  <= data;
         count_q <= amount;
         right_q <= right;
      end else if (count_q != '0) begin
         data_q  <= step;
         count_q <= count_q - 1'b1;
      end
   end

   // The final step is exposed combinationally so the owner can register the
   // finished value in the same cycle, giving exactly 'amount' shift cycles.
   assign value       = (count_q == '0) ? data_q : step;
   assign last        = (count_q <= SHAMT_W'(1));
   assign multi_cycle = 1'b1;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage with valid/ready handshakes on both sides.
// Build option BARREL_SHIFT_EN makes shift ops single-cycle (see alu_exec_shifter).
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int SHAMT_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic [SHAMT_W-1:0]    shamt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [3:0]            flags,
   output logic                  busy
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int IDX_W     = $clog2(NUM_BYTES);

   state_t                state;
   logic [3:0]            op_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [IDX_W-1:0]      byte_idx;

   logic                  shift_load;
   logic [DATA_WIDTH-1:0] shift_value;
   logic                  shift_last;
   logic                  shift_multi;

   logic [DATA_WIDTH-1:0] exec_res;
   logic [3:0]            exec_flg;
   logic [DATA_WIDTH-1:0] bypass_res;
   logic [3:0]            bypass_flg;
   logic [7:0]            scan_byte;
   logic [DATA_WIDTH-1:0] scan_index;

   function automatic logic [DATA_WIDTH-1:0] op_result(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [DATA_WIDTH-1:0] shifted
   );
      case (op)
         OP_AND:         return a & b;
         OP_ORR:         return a | b;
         OP_SUB:         return a - b;
         OP_XNOR:        return ~(a ^ b);
         OP_LSL, OP_LSR: return shifted;
         OP_SHCMP:       return (shifted == b) ? DATA_WIDTH'(1) : '0;
         default:        return a + b;
      endcase
   endfunction

   function automatic logic [3:0] op_flags(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [DATA_WIDTH-1:0] res
   );
      logic [DATA_WIDTH:0] wide;
      logic [3:0]          f;
      f         = '0;
      wide      = '0;
      f[FLAG_N] = res[DATA_WIDTH-1];
      f[FLAG_Z] = (res == '0);
      // Subtraction is A + ~B + 1, so the carry out means "no borrow".
      if (op == OP_SUB) begin
         wide      = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
         f[FLAG_C] = wide[DATA_WIDTH];
         f[FLAG_V] = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                     (res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end else if (has_carry_flags(op)) begin
         wide      = {1'b0, a} + {1'b0, b};
         f[FLAG_C] = wide[DATA_WIDTH];
         f[FLAG_V] = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                     (res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      return f;
   endfunction

   assign shift_load = in_ready && in_valid && is_shift_op(alu_op);

   alu_exec_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W)
   ) shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (shift_load),
      .right       (alu_op != OP_LSL),
      .data        (op_a),
      .amount      (shamt),
      .value       (shift_value),
      .last        (shift_last),
      .multi_cycle (shift_multi)
   );

   // A zero-amount shift is just A, so it can be resolved from the live inputs.
   always_comb begin
      exec_res   = op_result(op_q, a_q, b_q, shift_value);
      exec_flg   = op_flags(op_q, a_q, b_q, exec_res);
      bypass_res = op_result(alu_op, op_a, op_b, op_a);
      bypass_flg = op_flags(alu_op, op_a, op_b, bypass_res);
      scan_byte  = a_q[8*byte_idx +: 8];
      scan_index = {{(DATA_WIDTH-IDX_W){1'b0}}, byte_idx};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         flags     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         byte_idx  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q     <= alu_op;
                  a_q      <= op_a;
                  b_q      <= op_b;
                  byte_idx <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (alu_op == OP_SUBSTR) begin
                     state <= ST_SCAN;
                  end else if (is_shift_op(alu_op) && shift_multi) begin
                     if (shamt == '0) begin
                        result    <= bypass_res;
                        flags     <= bypass_flg;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                     end else begin
                        state <= ST_SHIFT;
                     end
                  end else begin
                     state <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               result    <= exec_res;
               flags     <= exec_flg;
               out_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_SHIFT: begin
               if (shift_last) begin
                  result    <= exec_res;
                  flags     <= exec_flg;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_SCAN: begin
               if (scan_byte == b_q[7:0]) begin
                  result    <= scan_index;
                  flags     <= op_flags(OP_SUBSTR, a_q, b_q, scan_index);
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else if (byte_idx == IDX_W'(NUM_BYTES-1)) begin
                  result    <= {DATA_WIDTH{1'b1}};
                  flags     <= op_flags(OP_SUBSTR, a_q, b_q, {DATA_WIDTH{1'b1}});
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, an arithmetic
// reference model with an expectation queue, and literal pins on key results.
module tb_alu_exec_unit;

   localparam int DW = 64;
   localparam int SW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_op;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [SW-1:0] shamt;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] result;
   logic [3:0]    flags;
   logic          busy;

   typedef struct packed {
      logic [DW-1:0] res;
      logic [3:0]    flg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(
      .DATA_WIDTH (DW),
      .SHAMT_W    (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   task automatic check_output(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference behaviour in plain arithmetic: flags are {N,Z,C,V}.
   function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [SW-1:0] sh);
      exp_t              e;
      logic [DW:0]       uns;
      logic signed [DW:0] sgn;
      e.flg = 4'b0000;
      e.res = '0;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0101: e.res = ~(a ^ b);
         4'b0111: e.res = a << sh;
         4'b1000: e.res = a >> sh;
         4'b1001: e.res = ((a >> sh) == b) ? DW'(1) : DW'(0);
         4'b1010: begin
            e.res = '1;
            for (int i = DW/8-1; i >= 0; i--)
               if (a[8*i +: 8] == b[7:0]) e.res = DW'(i);
         end
         4'b0110: begin
            e.res    = a - b;
            e.flg[1] = (a >= b);
            sgn      = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
            e.flg[0] = sgn[DW] ^ sgn[DW-1];
         end
         default: begin
            uns      = {1'b0, a} + {1'b0, b};
            e.res    = uns[DW-1:0];
            e.flg[1] = uns[DW];
            sgn      = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
            e.flg[0] = sgn[DW] ^ sgn[DW-1];
         end
      endcase
      e.flg[3] = e.res[DW-1];
      e.flg[2] = (e.res == '0);
      return e;
   endfunction

   // Edges after the accept edge until out_valid is visible.
   function automatic int exp_latency(input logic [3:0] op, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, input logic [SW-1:0] sh);
      case (op)
         4'b0111, 4'b1000, 4'b1001: begin
`ifdef BARREL_SHIFT_EN
            return 1;
`else
            return int'(sh);
`endif
         end
         4'b1010: begin
            for (int i = 0; i < DW/8; i++)
               if (a[8*i +: 8] == b[7:0]) return i + 1;
            return DW/8;
         end
         default: return 1;
      endcase
   endfunction

   // Outputs are compared against the queue head on every cycle they are valid.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_output", DW'(out_valid), DW'(0));
         end else begin
            check_output("model_result", result, exp_q[0].res);
            check_output("model_flags", DW'(flags), DW'(exp_q[0].flg));
            check_output("ready_while_valid", DW'(in_ready), DW'(0));
         end
      end
   end

   task automatic apply_stimulus(input logic [3:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [SW-1:0] sh);
      int wait_cycles = 0;
      @(negedge clk);
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      shamt    = sh;
      in_valid = 1'b1;
      while (!in_ready && wait_cycles < 200) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (!in_ready) begin
         check_output("accept_timeout", DW'(in_ready), DW'(1));
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back(model(op, a, b, sh));
         #1;
         in_valid = 1'b0;
         alu_op   = 4'($urandom);
         op_a     = {$urandom, $urandom};
         op_b     = {$urandom, $urandom};
         shamt    = SW'($urandom);
      end
   endtask

   task automatic wait_result(input int exp_lat, input string name);
      int lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_output({name, "_latency"}, DW'(lat), DW'(exp_lat));
   endtask

   task automatic check_release(input int stall);
      repeat (stall) @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      if (exp_q.size() > 0) exp_q.delete(0);
      #1;
      out_ready = 1'b0;
      check_output("post_handshake_valid", DW'(out_valid), DW'(0));
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [SW-1:0] sh, input bit pin,
                         input logic [DW-1:0] lit_res, input logic [3:0] lit_flg,
                         input int stall);
      exp_t m;
      apply_stimulus(op, a, b, sh);
      wait_result(exp_latency(op, a, b, sh), name);
      if (pin) begin
         m = model(op, a, b, sh);
         check_output({name, "_res"}, result, lit_res);
         check_output({name, "_flags"}, DW'(flags), DW'(lit_flg));
         check_output({name, "_model_res"}, m.res, lit_res);
         check_output({name, "_model_flags"}, DW'(m.flg), DW'(lit_flg));
      end
      check_release(stall);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_op    = 4'b0000;
      op_a      = '0;
      op_b      = '0;
      shamt     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_output("reset_in_ready", DW'(in_ready), DW'(1));
      check_output("reset_out_valid", DW'(out_valid), DW'(0));
      check_output("reset_result", result, DW'(0));
      check_output("reset_flags", DW'(flags), DW'(0));
      check_output("reset_busy", DW'(busy), DW'(0));

      // Reset in the middle of a long shift abandons it silently.
      apply_stimulus(4'b1000, 64'h8000_0000_0000_0000, 64'h0, 6'd40);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      check_output("midreset_out_valid", DW'(out_valid), DW'(0));
      check_output("midreset_result", result, DW'(0));
      check_output("midreset_busy", DW'(busy), DW'(0));
      check_output("midreset_in_ready", DW'(in_ready), DW'(1));
      repeat (50) @(negedge clk);
      check_output("midreset_still_idle", DW'(busy), DW'(0));

      run_op("sub_neg", 4'b0110, 64'd5, 64'd7, 6'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 0);
      run_op("and", 4'b0000, 64'hF0F0, 64'hFF00, 6'd0, 1'b1, 64'hF000, 4'b0000, 1);
      run_op("orr", 4'b0001, 64'hF0F0, 64'h0F0F, 6'd0, 1'b1, 64'hFFFF, 4'b0000, 0);
      run_op("xnor", 4'b0101, 64'h0, 64'h0, 6'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 2);
      run_op("add_carry", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, 64'h0, 4'b0110, 0);
      run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1,
             64'h8000_0000_0000_0000, 4'b1001, 0);
      run_op("sub_eq", 4'b0110, 64'd9, 64'd9, 6'd0, 1'b1, 64'h0, 4'b0110, 0);
      run_op("sub_ovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 6'd0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 0);
      run_op("default_add", 4'b1111, 64'd2, 64'd3, 6'd0, 1'b1, 64'd5, 4'b0000, 0);
      run_op("lsl8", 4'b0111, 64'h12, 64'h0, 6'd8, 1'b1, 64'h1200, 4'b0000, 0);
      run_op("lsl0_pass", 4'b0111, 64'hDEAD, 64'h1, 6'd0, 1'b1, 64'hDEAD, 4'b0000, 1);
      run_op("lsr63", 4'b1000, 64'h8000_0000_0000_0000, 64'h0, 6'd63, 1'b1, 64'd1, 4'b0000, 0);
      run_op("shcmp_hit", 4'b1001, 64'hF0, 64'hF, 6'd4, 1'b1, 64'd1, 4'b0000, 0);
      run_op("shcmp_miss", 4'b1001, 64'hF0, 64'hE, 6'd4, 1'b1, 64'd0, 4'b0100, 0);
      run_op("scan_hit", 4'b1010, 64'h0011_2233_4455_6677, 64'h33, 6'd0, 1'b1, 64'd4, 4'b0000, 0);
      run_op("scan_miss", 4'b1010, 64'h0011_2233_4455_6677, 64'hAA, 6'd0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 0);
      run_op("scan_byte0", 4'b1010, 64'h0011_2233_4455_6677, 64'h77, 6'd0, 1'b1, 64'd0, 4'b0100, 0);
      run_op("mixed", 4'b0010, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 6'd0, 1'b0,
             64'h0, 4'b0000, 0);

      // Backpressure: a second request waits while the first result is stalled.
      apply_stimulus(4'b0010, 64'd100, 64'd23, 6'd0);
      wait_result(1, "bp_first");
      @(negedge clk);
      alu_op   = 4'b0110;
      op_a     = 64'd50;
      op_b     = 64'd8;
      shamt    = 6'd0;
      in_valid = 1'b1;
      repeat (10) begin
         check_output("bp_in_ready", DW'(in_ready), DW'(0));
         check_output("bp_result_held", result, 64'd123);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      if (exp_q.size() > 0) exp_q.delete(0);
      #1;
      out_ready = 1'b0;
      check_output("bp_handshake_in_ready", DW'(in_ready), DW'(1));
      check_output("bp_handshake_busy", DW'(busy), DW'(0));
      check_output("bp_handshake_valid", DW'(out_valid), DW'(0));
      apply_stimulus(4'b0110, 64'd50, 64'd8, 6'd0);
      check_output("bp_second_busy", DW'(busy), DW'(1));
      wait_result(1, "bp_second");
      check_output("bp_second_res", result, 64'd42);
      check_release(0);

      repeat (5) @(negedge clk);
      check_output("final_queue_empty", DW'(exp_q.size()), DW'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
